// File: rtl/vec_pipe_datapath.sv
// Parameterised E/M/W vector pipeline slice with forwarding, load-use stall, flush and strided addresses.
// Define VEC_SAT_EN for unsigned per-lane saturation of ADD/SUB; the default build wraps.

module vec_pipe_lane #(
   parameter int WIDTH = 18
) (
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] res_o
);
   logic [WIDTH-1:0] add_r, sub_r;

`ifdef VEC_SAT_EN
   logic [WIDTH:0] sum, dif;
   assign sum   = {1'b0, a_i} + {1'b0, b_i};
   assign dif   = {1'b0, a_i} - {1'b0, b_i};
   assign add_r = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
   assign sub_r = dif[WIDTH] ? '0 : dif[WIDTH-1:0];
`else
   assign add_r = a_i + b_i;
   assign sub_r = a_i - b_i;
`endif

   always_comb begin
      res_o = '0;
      case (op_i)
         3'b000: res_o = add_r;
         3'b001: res_o = sub_r;
         3'b010: res_o = a_i & b_i;
         3'b011: res_o = a_i | b_i;
         3'b100: res_o = a_i ^ b_i;
         3'b101: res_o = {a_i[WIDTH-2:0], 1'b0};
         3'b110: res_o = (a_i > b_i) ? a_i : b_i;
         3'b111: res_o = b_i;
      endcase
   end
endmodule

module vec_pipe_datapath #(
   parameter int LANES  = 3,
   parameter int WIDTH  = 18,
   parameter int ADDR_W = 10,
   parameter int REG_AW = 4,
   parameter int STRIDE = 1
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [2:0]             op,
   input  logic [REG_AW-1:0]      ra,
   input  logic [REG_AW-1:0]      rb,
   input  logic [LANES*WIDTH-1:0] rd1,
   input  logic [LANES*WIDTH-1:0] rd2,
   input  logic [WIDTH-1:0]       imm,
   input  logic                   use_imm,
   input  logic                   reg_write,
   input  logic                   mem_to_reg,
   input  logic                   mem_write,
   input  logic [REG_AW-1:0]      wa,
   input  logic                   flush,
   output logic [ADDR_W-1:0]      mem_addr,
   output logic [ADDR_W-1:0]      addr_prev,
   output logic [ADDR_W-1:0]      addr_next,
   output logic                   mem_we,
   output logic [LANES*WIDTH-1:0] mem_wdata,
   input  logic [LANES*WIDTH-1:0] mem_rdata,
   output logic                   wb_we,
   output logic [REG_AW-1:0]      wb_wa,
   output logic [LANES*WIDTH-1:0] wb_data,
   output logic [3:0]             flags
);
   localparam int DW = LANES * WIDTH;

   typedef struct packed {
      logic [2:0]        op;
      logic [REG_AW-1:0] ra, rb, wa;
      logic [DW-1:0]     rd1, rd2;
      logic [WIDTH-1:0]  imm;
      logic              use_imm, rw, m2r, mw;
   } e_t;

   typedef struct packed {
      logic [DW-1:0]     res, sdat;
      logic [REG_AW-1:0] wa;
      logic              rw, m2r, mw;
   } m_t;

   typedef struct packed {
      logic [DW-1:0]     res;
      logic [REG_AW-1:0] wa;
      logic              rw, m2r;
   } w_t;

   // vld bits: [0]=E, [1]=M, [2]=W
   logic [2:0] vld_q, vld_d;
   e_t         e_q, e_d;
   m_t         m_q, m_d;
   w_t         w_q, w_d;
   logic [3:0] flags_q, flags_d;

   logic hazard, accept, m_fwd_ok;
   logic [DW-1:0] opa, regb, opb;
   logic [LANES-1:0][WIDTH-1:0] a_l, b_l, res_l;
   logic [WIDTH:0] a0x, b0x;
   logic is_add, is_sub, add_c, add_m, sub_bw, sub_m, fl_c, fl_v;

   assign hazard   = vld_q[0] & e_q.m2r & e_q.rw & ((e_q.wa == ra) | (e_q.wa == rb));
   assign in_ready = ~flush & ~hazard;
   assign accept   = in_valid & in_ready;

   // Loads in M have no data yet; their consumers were stalled onto the W path.
   assign m_fwd_ok = vld_q[1] & m_q.rw & ~m_q.m2r;
   assign opa  = (m_fwd_ok && m_q.wa == e_q.ra) ? m_q.res :
                 (wb_we && wb_wa == e_q.ra)     ? wb_data : e_q.rd1;
   assign regb = (m_fwd_ok && m_q.wa == e_q.rb) ? m_q.res :
                 (wb_we && wb_wa == e_q.rb)     ? wb_data : e_q.rd2;
   assign opb  = e_q.use_imm ? {LANES{e_q.imm}} : regb;
   assign a_l  = opa;
   assign b_l  = opb;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      vec_pipe_lane #(.WIDTH(WIDTH)) u_lane (
         .op_i  (e_q.op),
         .a_i   (a_l[i]),
         .b_i   (b_l[i]),
         .res_o (res_l[i])
      );
   end

   // Carry and overflow come from the unsaturated lane-0 arithmetic.
   assign a0x    = {1'b0, a_l[0]};
   assign b0x    = {1'b0, b_l[0]};
   assign add_c  = 1'((a0x + b0x) >> WIDTH);
   assign add_m  = 1'((a0x + b0x) >> (WIDTH - 1));
   assign sub_bw = 1'((a0x - b0x) >> WIDTH);
   assign sub_m  = 1'((a0x - b0x) >> (WIDTH - 1));
   assign is_add = (e_q.op == 3'b000);
   assign is_sub = (e_q.op == 3'b001);
   assign fl_c   = (is_add & add_c) | (is_sub & ~sub_bw);
   assign fl_v   = (is_add & (a_l[0][WIDTH-1] == b_l[0][WIDTH-1]) & (add_m != a_l[0][WIDTH-1])) |
                   (is_sub & (a_l[0][WIDTH-1] != b_l[0][WIDTH-1]) & (sub_m != a_l[0][WIDTH-1]));

   always_comb begin
      vld_d = {vld_q[1] & ~flush, vld_q[0] & ~flush, accept};
      e_d   = e_q;
      if (accept) begin
         e_d.op      = op;
         e_d.ra      = ra;
         e_d.rb      = rb;
         e_d.wa      = wa;
         e_d.rd1     = rd1;
         e_d.rd2     = rd2;
         e_d.imm     = imm;
         e_d.use_imm = use_imm;
         e_d.rw      = reg_write;
         e_d.m2r     = mem_to_reg;
         e_d.mw      = mem_write;
      end
      m_d.res  = res_l;
      m_d.sdat = regb;
      m_d.wa   = e_q.wa;
      m_d.rw   = e_q.rw;
      m_d.m2r  = e_q.m2r;
      m_d.mw   = e_q.mw;
      w_d.res  = m_q.res;
      w_d.wa   = m_q.wa;
      w_d.rw   = m_q.rw;
      w_d.m2r  = m_q.m2r;
      flags_d  = vld_q[0] ? {res_l[0][WIDTH-1], res_l[0] == '0, fl_c, fl_v} : flags_q;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         vld_q   <= '0;
         e_q     <= '0;
         m_q     <= '0;
         w_q     <= '0;
         flags_q <= '0;
      end else begin
         vld_q   <= vld_d;
         e_q     <= e_d;
         m_q     <= m_d;
         w_q     <= w_d;
         flags_q <= flags_d;
      end
   end

   assign mem_addr  = m_q.res[ADDR_W-1:0];
   assign addr_next = mem_addr + ADDR_W'(STRIDE);
   assign addr_prev = mem_addr - ADDR_W'(STRIDE);
   assign mem_we    = vld_q[1] & m_q.mw;
   assign mem_wdata = m_q.sdat;
   assign wb_we     = vld_q[2] & w_q.rw;
   assign wb_wa     = w_q.wa;
   assign wb_data   = w_q.m2r ? mem_rdata : w_q.res;
   assign flags     = flags_q;
endmodule

// File: tb/tb_vec_pipe_datapath.sv
// Directed bench for vec_pipe_datapath (3 lanes x 18 bits, ADDR_W=10, STRIDE=2).
module tb_vec_pipe_datapath;
   logic        CLK = 1'b0;
   logic        RST, in_valid, in_ready, use_imm, reg_write, mem_to_reg, mem_write, flush;
   logic        mem_we, wb_we;
   logic [2:0]  op;
   logic [3:0]  ra, rb, wa, wb_wa, flags;
   logic [17:0] imm;
   logic [53:0] rd1, rd2, mem_wdata, mem_rdata, wb_data;
   logic [9:0]  mem_addr, addr_prev, addr_next;

   int nvec = 0;
   int nerr = 0;
   logic [2:0]  sw_op  [6];
   logic [53:0] sw_exp [6];
   logic [53:0] ov_rd  [3];
   logic [2:0]  ov_op  [3];
   logic [3:0]  ov_fl  [3];
   logic [53:0] ov_wb  [3];

   always #5 CLK = ~CLK;

   vec_pipe_datapath #(.LANES(3), .WIDTH(18), .ADDR_W(10), .REG_AW(4), .STRIDE(2)) dut (
      .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .ra(ra), .rb(rb), .rd1(rd1), .rd2(rd2), .imm(imm), .use_imm(use_imm),
      .reg_write(reg_write), .mem_to_reg(mem_to_reg), .mem_write(mem_write), .wa(wa),
      .flush(flush), .mem_addr(mem_addr), .addr_prev(addr_prev), .addr_next(addr_next),
      .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .wb_we(wb_we),
      .wb_wa(wb_wa), .wb_data(wb_data), .flags(flags)
   );

   function automatic logic [53:0] pk(input int a0, input int a1, input int a2);
      return {a2[17:0], a1[17:0], a0[17:0]};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic iss(input logic [2:0] o, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] w, input logic [53:0] r1, input logic [53:0] r2,
                      input logic [17:0] im, input logic ui, input logic rw,
                      input logic m2r, input logic mw);
      in_valid = 1'b1; op = o; ra = a; rb = b; wa = w; rd1 = r1; rd2 = r2; imm = im;
      use_imm = ui; reg_write = rw; mem_to_reg = m2r; mem_write = mw;
   endtask

   task automatic idle();
      in_valid = 1'b0; reg_write = 1'b0; mem_to_reg = 1'b0; mem_write = 1'b0;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      sw_op  = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
      sw_exp = '{pk(18'h0F0, 18'h0FF, 1), pk(18'h0FF, 18'h3FFFF, 18'h0FF),
                 pk(18'h00F, 18'h3FF00, 18'h0FE), pk(18'h1E0, 18'h3FFFE, 2),
                 pk(18'h0FF, 18'h3FFFF, 18'h0FF), pk(18'h0FF, 18'h0FF, 18'h0FF)};
      ov_op  = '{3'd0, 3'd0, 3'd1};
      ov_rd  = '{pk(18'h3FFFF, 0, 0), pk(18'h1FFFF, 0, 0), pk(0, 0, 0)};
`ifdef VEC_SAT_EN
      ov_fl  = '{4'b1010, 4'b1001, 4'b0100};
      ov_wb  = '{pk(18'h3FFFF, 1, 1), pk(18'h20000, 1, 1), pk(0, 0, 0)};
`else
      ov_fl  = '{4'b0110, 4'b1001, 4'b1000};
      ov_wb  = '{pk(0, 1, 1), pk(18'h20000, 1, 1), pk(18'h3FFFF, 18'h3FFFF, 18'h3FFFF)};
`endif
      RST = 1'b1; flush = 1'b0; mem_rdata = '0;
      op = '0; ra = '0; rb = '0; wa = '0; rd1 = '0; rd2 = '0; imm = '0; use_imm = 1'b0;
      idle();
      tick(); tick();
      RST = 1'b0; #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_wb_we",    64'(wb_we),    64'd0);
      chk("rst_mem_we",   64'(mem_we),   64'd0);
      chk("rst_flags",    64'(flags),    64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);

      // back-to-back ADDs: M forwarding, then M+W forwarding into a SUB
      iss(3'd0, 4'd5, 4'd6, 4'd1, pk(5, 6, 7), pk(100, 100, 100), 18'd3, 1, 1, 0, 0); #1;
      chk("b2b_rdy0", 64'(in_ready), 64'd1);
      tick();
      iss(3'd0, 4'd1, 4'd1, 4'd2, pk(100, 100, 100), pk(100, 100, 100), 18'd0, 0, 1, 0, 0); #1;
      chk("b2b_rdy1", 64'(in_ready), 64'd1);
      tick();
      iss(3'd1, 4'd2, 4'd1, 4'd5, pk(100, 100, 100), pk(100, 100, 100), 18'd0, 0, 1, 0, 0); #1;
      chk("b2b_addr", 64'(mem_addr),  64'd8);
      chk("b2b_next", 64'(addr_next), 64'd10);
      chk("b2b_prev", 64'(addr_prev), 64'd6);
      tick();
      idle(); #1;
      chk("b2b_we1",   64'(wb_we),   64'd1);
      chk("b2b_wa1",   64'(wb_wa),   64'd1);
      chk("b2b_data1", 64'(wb_data), 64'(pk(8, 9, 10)));
      tick();
      chk("b2b_wa2",   64'(wb_wa),   64'd2);
      chk("b2b_data2", 64'(wb_data), 64'(pk(16, 18, 20)));
      chk("sub_flags", 64'(flags),   64'b0010);
      tick();
      chk("fwd_mw_wa",   64'(wb_wa),   64'd5);
      chk("fwd_mw_data", 64'(wb_data), 64'(pk(8, 9, 10)));
      tick();

      // logic/shift/max/pass sweep, fully pipelined
      for (int k = 0; k < 9; k++) begin
         if (k < 6) iss(sw_op[k], 4'd7, 4'd8, 4'(9 + k), pk(18'h0F0, 18'h3FFFF, 1), pk(0, 0, 0),
                        18'h0FF, 1, 1, 0, 0);
         else idle();
         #1;
         if (k >= 3) begin
            chk("sweep_we",   64'(wb_we),   64'd1);
            chk("sweep_wa",   64'(wb_wa),   64'(9 + k - 3));
            chk("sweep_data", 64'(wb_data), 64'(sw_exp[k-3]));
         end
         tick();
      end

      // load-use: load r3 from 0x010, then r4 <- r3 + r3
      iss(3'd0, 4'd9, 4'd9, 4'd3, pk(16, 0, 0), pk(100, 100, 100), 18'd0, 1, 1, 1, 0); #1;
      chk("lu_rdy_load", 64'(in_ready), 64'd1);
      tick();
      iss(3'd0, 4'd3, 4'd3, 4'd4, pk(100, 100, 100), pk(100, 100, 100), 18'd0, 0, 1, 0, 0); #1;
      chk("lu_stall", 64'(in_ready), 64'd0);
      tick();
      chk("lu_rdy_after", 64'(in_ready), 64'd1);
      chk("lu_addr",      64'(mem_addr), 64'h010);
      chk("lu_no_store",  64'(mem_we),   64'd0);
      mem_rdata = pk(1, 2, 3);
      tick();
      idle(); #1;
      chk("lu_load_we",   64'(wb_we),   64'd1);
      chk("lu_load_wa",   64'(wb_wa),   64'd3);
      chk("lu_load_data", 64'(wb_data), 64'(pk(1, 2, 3)));
      tick();
      chk("lu_bubble", 64'(wb_we), 64'd0);
      tick();
      chk("lu_use_we",   64'(wb_we),   64'd1);
      chk("lu_use_wa",   64'(wb_wa),   64'd4);
      chk("lu_use_data", 64'(wb_data), 64'(pk(2, 4, 6)));
      mem_rdata = '0;
      tick();

      // neighbour address wrap at both ends
      iss(3'd7, 4'd0, 4'd0, 4'd0, pk(0, 0, 0), pk(0, 0, 0), 18'd0, 1, 0, 0, 0);
      tick();
      iss(3'd7, 4'd0, 4'd0, 4'd0, pk(0, 0, 0), pk(0, 0, 0), 18'h3FF, 1, 0, 0, 0);
      tick();
      idle(); #1;
      chk("wrap_addr0", 64'(mem_addr),  64'd0);
      chk("wrap_prev0", 64'(addr_prev), 64'h3FE);
      chk("wrap_next0", 64'(addr_next), 64'h002);
      tick();
      chk("wrap_addr1", 64'(mem_addr),  64'h3FF);
      chk("wrap_next1", 64'(addr_next), 64'h001);
      chk("wrap_prev1", 64'(addr_prev), 64'h3FD);
      tick();

      // flush kills a store in E while an older ADD in W still writes back
      iss(3'd0, 4'd0, 4'd0, 4'd7, pk(1, 1, 1), pk(0, 0, 0), 18'd4, 1, 1, 0, 0);
      tick();
      idle();
      tick();
      iss(3'd0, 4'd0, 4'd0, 4'd0, pk(32, 0, 0), pk(9, 9, 9), 18'd0, 1, 0, 0, 1);
      tick();
      iss(3'd0, 4'd0, 4'd0, 4'd8, pk(1, 1, 1), pk(0, 0, 0), 18'd1, 1, 1, 0, 0);
      flush = 1'b1; #1;
      chk("fl_rdy",     64'(in_ready), 64'd0);
      chk("fl_w_we",    64'(wb_we),    64'd1);
      chk("fl_w_wa",    64'(wb_wa),    64'd7);
      chk("fl_w_data",  64'(wb_data),  64'(pk(5, 5, 5)));
      chk("fl_mem_we0", 64'(mem_we),   64'd0);
      tick();
      flush = 1'b0; idle(); #1;
      chk("fl_mem_we1", 64'(mem_we), 64'd0);
      chk("fl_wb_we1",  64'(wb_we),  64'd0);
      tick();
      chk("fl_mem_we2", 64'(mem_we), 64'd0);
      chk("fl_wb_we2",  64'(wb_we),  64'd0);
      tick();
      chk("fl_noissue", 64'(wb_we), 64'd0);
      tick();

      // carry / overflow / borrow flags and wrap-or-saturate results
      for (int k = 0; k < 6; k++) begin
         if (k < 3) iss(ov_op[k], 4'd0, 4'd0, 4'(10 + k), ov_rd[k], pk(0, 0, 0), 18'd1, 1, 1, 0, 0);
         else idle();
         #1;
         if (k >= 2) chk("ov_flags", 64'(flags), 64'(ov_fl[(k - 2 > 2) ? 2 : k - 2]));
         if (k >= 3) chk("ov_data", 64'(wb_data), 64'(ov_wb[k-3]));
         tick();
      end

      // reset mid-flight discards the instruction
      iss(3'd0, 4'd0, 4'd0, 4'd11, pk(1, 1, 1), pk(0, 0, 0), 18'd1, 1, 1, 0, 0);
      tick();
      idle();
      tick();
      RST = 1'b1;
      tick();
      RST = 1'b0; #1;
      chk("rst_mid_we0",  64'(wb_we),    64'd0);
      chk("rst_mid_addr", 64'(mem_addr), 64'd0);
      chk("rst_mid_fl",   64'(flags),    64'd0);
      tick();
      chk("rst_mid_we1", 64'(wb_we), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
